// File: rtl/spi_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_burst_arbiter
//  Purpose  : Round-robin burst arbiter that shares one spi_core byte engine
//             between NREQ requesters. Each requester has its own active-low
//             slave select. The module streams req_len+1 bytes per burst and
//             owns slave-select setup and hold timing.
//  Revision : 1.0  initial release
// ============================================================================
module spi_burst_arbiter #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 2,
    parameter int LENW   = 4,
    parameter int SETUP  = 2,
    parameter int HOLD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LENW-1:0]   req_len,
    output logic [NREQ-1:0]        gnt,
    input  logic [DWIDTH-1:0]      tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [DWIDTH-1:0]      rx_data,
    output logic                   rx_valid,
    output logic                   last,
    output logic [NREQ-1:0]        ss_n,
    output logic                   core_cs,
    output logic                   core_wr,
    output logic                   core_rd,
    output logic [DWIDTH-1:0]      core_din,
    input  logic [DWIDTH-1:0]      core_dout,
    input  logic                   core_done
);

    localparam int c_PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TMAX = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SETUP = 4'd1,
        S_LOAD  = 4'd2,
        S_START = 4'd3,
        S_WBUSY = 4'd4,
        S_WDONE = 4'd5,
        S_CAPT  = 4'd6,
        S_HOLD  = 4'd7,
        S_GAP   = 4'd8
    } state_t;

    state_t              r_state;
    logic [c_PTRW-1:0]   r_ptr;
    logic [LENW-1:0]     r_cnt;
    logic [c_TW-1:0]     r_tmr;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ss_n;
    logic [DWIDTH-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_last;
    logic                r_core_cs;
    logic                r_core_wr;
    logic [DWIDTH-1:0]   r_core_din;

    int                  w_idx;
    logic                w_any;
    logic [c_PTRW-1:0]   w_win;
    logic [c_PTRW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0]     w_onehot;
    logic [LENW-1:0]     w_len;

    // Round-robin pick: scan from the pointer downward so the requester
    // closest to (at or after) the pointer is the last one written and wins.
    always_comb begin
        w_idx = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req[c_PTRW'(w_idx)]) begin
                w_win = c_PTRW'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_win == c_PTRW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_len     = req_len[w_win*LENW +: LENW];

    // Burst sequencer: grant, slave-select setup, one byte at a time through
    // the core, capture, then slave-select hold and a guaranteed idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_gnt      <= '0;
            r_ss_n     <= '1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_last     <= 1'b0;
            r_core_cs  <= 1'b0;
            r_core_wr  <= 1'b0;
            r_core_din <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_last     <= 1'b0;
            r_core_cs  <= 1'b0;
            r_core_wr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The core may still be finishing a byte abandoned by a
                    // reset, so a new burst waits for it to report idle.
                    if (core_done && w_any) begin
                        r_gnt   <= w_onehot;
                        r_ss_n  <= ~w_onehot;
                        r_cnt   <= w_len;
                        r_ptr   <= w_ptr_nxt;
                        r_tmr   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_tmr == c_TW'(SETUP - 1)) begin
                        r_tmr   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (tx_valid && core_done) begin
                        r_core_din <= tx_data;
                        r_core_cs  <= 1'b1;
                        r_core_wr  <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WBUSY;
                end
                S_WBUSY: begin
                    if (!core_done) begin
                        r_state <= S_WDONE;
                    end
                end
                S_WDONE: begin
                    // First done rise after the fall: the byte is complete.
                    if (core_done) begin
                        r_rx_data  <= core_dout;
                        r_rx_valid <= 1'b1;
                        r_last     <= (r_cnt == '0);
                        r_state    <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (r_cnt != '0) begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_tmr   <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_tmr == c_TW'(HOLD - 1)) begin
                        r_tmr   <= '0;
                        r_ss_n  <= '1;
                        r_gnt   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte handshake is open only while waiting to load and the core is idle.
    assign tx_ready = (r_state == S_LOAD) && core_done;

    assign gnt      = r_gnt;
    assign ss_n     = r_ss_n;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign last     = r_last;
    assign core_cs  = r_core_cs;
    assign core_wr  = r_core_wr;
    assign core_rd  = 1'b0;
    assign core_din = r_core_din;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_burst_arbiter
//  Purpose  : Self-checking bench for spi_burst_arbiter with a behavioural
//             spi_core model (loopback) and a round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_burst_arbiter;

    localparam int DWIDTH = 8;
    localparam int NREQ   = 2;
    localparam int LENW   = 4;
    localparam int SETUP  = 3;
    localparam int HOLD   = 2;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic [NREQ-1:0]      req       = '0;
    logic [NREQ*LENW-1:0] req_len   = '0;
    logic [NREQ-1:0]      gnt;
    logic [DWIDTH-1:0]    tx_data   = '0;
    logic                 tx_valid  = 1'b0;
    logic                 tx_ready;
    logic [DWIDTH-1:0]    rx_data;
    logic                 rx_valid;
    logic                 last;
    logic [NREQ-1:0]      ss_n;
    logic                 core_cs;
    logic                 core_wr;
    logic                 core_rd;
    logic [DWIDTH-1:0]    core_din;
    logic [DWIDTH-1:0]    core_dout = '0;
    logic                 core_done = 1'b1;

    spi_burst_arbiter #(
        .DWIDTH(DWIDTH), .NREQ(NREQ), .LENW(LENW), .SETUP(SETUP), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .last(last), .ss_n(ss_n),
        .core_cs(core_cs), .core_wr(core_wr), .core_rd(core_rd),
        .core_din(core_din), .core_dout(core_dout), .core_done(core_done)
    );

    always #5 clk = ~clk;

    // spi_core model: done falls 1-2 cycles after an accepted write, stays low
    // a variable time with garbage on dout, then rises with the looped-back byte.
    logic              m_pend     = 1'b0;
    int                m_fall     = 0;
    int                m_busy     = 0;
    logic [DWIDTH-1:0] m_data     = '0;
    bit                force_long = 1'b0;

    always @(posedge clk) begin
        if (core_done && !m_pend) begin
            if (core_wr) begin
                m_pend <= 1'b1;
                m_data <= core_din;
                m_fall <= int'($urandom_range(0, 1));
            end
        end else if (core_done && m_pend) begin
            if (m_fall == 0) begin
                core_done <= 1'b0;
                core_dout <= 8'($urandom);
                m_busy    <= force_long ? 8 : int'($urandom_range(0, 5));
            end else begin
                m_fall <= m_fall - 1;
            end
        end else begin
            if (m_busy == 0) begin
                core_done <= 1'b1;
                core_dout <= m_data;
                m_pend    <= 1'b0;
            end else begin
                m_busy    <= m_busy - 1;
                core_dout <= 8'($urandom);
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first requesting index at or after ptr, wrapping.
    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference-model and observation state
    int                cyc         = 0;
    int                mptr        = 0;
    int                exp_nbytes  = 0;
    int                burst_nrx   = 0;
    int                burst_nwr   = 0;
    int                t_fall      = 0;
    int                t_first_wr  = -1;
    int                t_last_rx   = 0;
    int                t_rise      = 0;
    int                last_grant  = -1;
    bit                have_rise   = 1'b0;
    bit                tx_hold     = 1'b0;
    logic              prev_all_hi = 1'b1;
    logic [NREQ-1:0]   prev_gnt    = '0;
    logic [DWIDTH-1:0] exp_q[$];
    int                grant_log[$];

    // One clock: advance, sample #1 after the edge, run the model and drive tx.
    task automatic tick();
        logic                 acc, rst_b, done_b, all_hi;
        logic [NREQ-1:0]      req_b, ngnt;
        logic [NREQ*LENW-1:0] len_b;
        int                   w;
        acc    = tx_valid && tx_ready;
        rst_b  = rst;
        done_b = core_done;
        req_b  = req;
        len_b  = req_len;
        @(posedge clk);
        #1;
        cyc++;
        all_hi = &ss_n;
        chk("ss_n_onecold", 32'($countones(~ss_n) <= 1), 1);
        if (rst_b) begin
            chk("rst_ss_n_high", ss_n, {NREQ{1'b1}});
            mptr = 0;
            exp_q.delete();
            burst_nrx  = 0;
            burst_nwr  = 0;
            exp_nbytes = 0;
            if (!prev_all_hi && all_hi) begin
                t_rise    = cyc;
                have_rise = 1'b1;
            end
        end else begin
            if (acc) exp_q.push_back(tx_data);
            if (gnt != '0 && prev_gnt == '0) begin
                w    = rr_pick(mptr, req_b);
                ngnt = ~gnt;
                chk("grant_onehot", 32'($onehot(gnt)), 1);
                chk("grant_winner", gnt, (w < 0) ? 0 : (1 << w));
                chk("grant_ss_n", ss_n, ngnt);
                chk("grant_core_idle", done_b, 1);
                for (int i = 0; i < NREQ; i++) if (gnt[i]) last_grant = i;
                grant_log.push_back(last_grant);
                if (w >= 0) begin
                    exp_nbytes = int'(len_b[w*LENW +: LENW]) + 1;
                    mptr       = (w + 1) % NREQ;
                end
                burst_nrx  = 0;
                burst_nwr  = 0;
                t_first_wr = -1;
            end
            if (core_wr || core_cs) chk("core_cs_eq_wr", core_cs, core_wr);
            if (core_wr) begin
                chk("wr_core_idle", core_done && !m_pend, 1);
                chk("wr_in_burst", gnt != '0, 1);
                chk("core_rd_zero", core_rd, 0);
                burst_nwr++;
                if (t_first_wr < 0) t_first_wr = cyc;
            end
            if (rx_valid) begin
                burst_nrx++;
                if (exp_q.size() == 0) chk("rx_unexpected", rx_valid, 0);
                else chk("rx_data", rx_data, exp_q.pop_front());
                chk("rx_last", last, burst_nrx == exp_nbytes);
                if (last) t_last_rx = cyc;
            end
            if (prev_all_hi && !all_hi) begin
                t_fall = cyc;
                if (have_rise) chk("gap_cycles", 32'((cyc - t_rise) >= 2), 1);
            end
            if (!prev_all_hi && all_hi) begin
                t_rise    = cyc;
                have_rise = 1'b1;
                chk("burst_rx_count", burst_nrx, exp_nbytes);
                chk("burst_wr_count", burst_nwr, exp_nbytes);
                chk("release_gnt", gnt, 0);
                chk("hold_cycles", cyc - t_last_rx, HOLD + 1);
            end
        end
        prev_all_hi = all_hi;
        prev_gnt    = gnt;
        if (acc) tx_valid = 1'b0;
        if (gnt != '0 && !tx_hold && !rst) begin
            if (!tx_valid) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_grant(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            tick();
            if (gnt != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            tick();
            if (gnt == '0 && (&ss_n)) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [LENW-1:0] len0;
        logic [LENW-1:0] len1;
        int              exp_gnt;
        int              exp_bytes;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        bit ok, bad;
        int n0;

        vecs[0] = '{2'b01, 4'd0,  4'd0, 0,  1};
        vecs[1] = '{2'b01, 4'd3,  4'd0, 0,  4};
        vecs[2] = '{2'b10, 4'd0,  4'd1, 1,  2};
        vecs[3] = '{2'b11, 4'd2,  4'd0, 0,  3};
        vecs[4] = '{2'b11, 4'd0,  4'd5, 1,  6};
        vecs[5] = '{2'b10, 4'd0,  4'd15, 1, 16};
        vecs[6] = '{2'b11, 4'd7,  4'd1, 0,  8};
        vecs[7] = '{2'b11, 4'd1,  4'd2, 1,  3};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_ss_n", ss_n, {NREQ{1'b1}});
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_core_cs", core_cs, 0);
        chk("rst_core_wr", core_wr, 0);
        chk("rst_core_rd", core_rd, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;

        // Directed single bursts with hand-derived winners and byte counts
        for (int i = 0; i < NV; i++) begin
            req     = vecs[i].req;
            req_len = {vecs[i].len1, vecs[i].len0};
            wait_grant(50, ok);
            chk("tbl_grant_seen", ok, 1);
            req = '0;
            if (ok) begin
                chk("tbl_winner", last_grant, vecs[i].exp_gnt);
                wait_idle(3000, ok);
                chk("tbl_release_seen", ok, 1);
                chk("tbl_rx_bytes", burst_nrx, vecs[i].exp_bytes);
                chk("tbl_wr_pulses", burst_nwr, vecs[i].exp_bytes);
                chk("tbl_setup_cycles", t_first_wr - t_fall, SETUP + 1);
            end
        end

        // Withheld tx_valid while loading: no write, tx_ready held high
        tx_hold = 1'b1;
        req     = 2'b01;
        req_len = {4'd0, 4'd1};
        wait_grant(50, ok);
        chk("stall_grant_seen", ok, 1);
        req = '0;
        ok  = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            tick();
            if (tx_ready) ok = 1'b1;
        end
        chk("stall_ready_seen", ok, 1);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!tx_ready || core_wr) bad = 1'b1;
        end
        chk("stall_ready_no_wr", bad, 0);
        chk("stall_wr_count", burst_nwr, 0);
        tx_hold = 1'b0;
        wait_idle(500, ok);
        chk("stall_release_seen", ok, 1);
        chk("stall_rx_bytes", burst_nrx, 2);

        // Reset while waiting for byte 2 of 4 to complete
        force_long = 1'b1;
        req        = 2'b01;
        req_len    = {4'd0, 4'd3};
        ok         = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            if (burst_nwr == 2 && !core_done) ok = 1'b1;
        end
        chk("abort_reached_byte2", ok, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ss_n", ss_n, {NREQ{1'b1}});
        chk("abort_gnt", gnt, 0);
        chk("abort_rx_valid", rx_valid, 0);
        bad = 1'b0;
        for (int c = 0; c < 50 && !core_done; c++) begin
            tick();
            if (gnt != '0 || rx_valid) bad = 1'b1;
        end
        chk("abort_no_grant_while_busy", bad, 0);
        force_long = 1'b0;
        wait_grant(20, ok);
        chk("abort_regrant_seen", ok, 1);
        req = '0;
        wait_idle(1000, ok);
        chk("abort_release_seen", ok, 1);
        chk("abort_rx_bytes", burst_nrx, 4);

        // Both requesters held: strict alternation starting from 0
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        req     = 2'b11;
        req_len = {4'd1, 4'd1};
        n0      = grant_log.size();
        ok      = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            tick();
            if (grant_log.size() >= n0 + 4) ok = 1'b1;
        end
        req = '0;
        chk("rr_four_grants", ok, 1);
        if (ok) begin
            for (int k = 0; k < 4; k++) chk("rr_order", grant_log[n0 + k], k % 2);
        end
        wait_idle(500, ok);
        chk("rr_release_seen", ok, 1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 8000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i] && $urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if (!gnt[i] && $urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                    req_len[i*LENW +: LENW] = ($urandom_range(0, 4) == 0) ?
                        LENW'($urandom) : LENW'($urandom_range(0, 2));
                end
            end
            tx_hold = ($urandom_range(0, 9) == 0);
            tick();
        end
        req     = '0;
        tx_hold = 1'b0;
        wait_idle(3000, ok);
        chk("rand_drain", ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
